// File: rtl/count_seq_checker.sv
// Checks that a sampled counter bus advances by exactly one each clock, modulo 2^CNT_WIDTH.
// It reports wraps and sequence errors, keeps saturating statistics, and latches a fault at ERR_LIMIT errors.
module count_seq_checker #(
   parameter int CNT_WIDTH  = 4,
   parameter int WRAP_WIDTH = 8,
   parameter int ERR_WIDTH  = 8,
   parameter int ERR_LIMIT  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CNT_WIDTH-1:0]  count,
   input  logic                  clr,
   output logic                  locked,
   output logic                  wrap_pulse,
   output logic                  err_pulse,
   output logic [WRAP_WIDTH-1:0] wrap_count,
   output logic [ERR_WIDTH-1:0]  err_count,
   output logic                  fault
);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [WRAP_WIDTH-1:0] WRAP_ONE = WRAP_WIDTH'(1);
   localparam logic [WRAP_WIDTH-1:0] WRAP_MAX = '1;
   localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = ERR_WIDTH'(1);
   localparam logic [ERR_WIDTH-1:0]  ERR_MAX  = '1;
   localparam logic [ERR_WIDTH-1:0]  ERR_LIM  = ERR_WIDTH'(ERR_LIMIT);

   state_t                state, state_nxt;
   logic [CNT_WIDTH-1:0]  prev;
   logic [CNT_WIDTH-1:0]  expected;
   logic                  prev_valid, prev_valid_nxt;
   logic [WRAP_WIDTH-1:0] wrap_count_nxt;
   logic [ERR_WIDTH-1:0]  err_count_nxt;
   logic [ERR_WIDTH-1:0]  err_count_inc;
   logic                  wrap_pulse_nxt, err_pulse_nxt;
   logic                  is_wrap, is_err;

   assign expected      = prev + CNT_ONE;
   assign is_wrap       = (prev == CNT_MAX) && (count == '0);
   assign is_err        = (count != expected);
   assign err_count_inc = (err_count == ERR_MAX) ? err_count : err_count + ERR_ONE;

   always_comb begin
      state_nxt      = state;
      prev_valid_nxt = prev_valid;
      wrap_count_nxt = wrap_count;
      err_count_nxt  = err_count;
      wrap_pulse_nxt = 1'b0;
      err_pulse_nxt  = 1'b0;

      if (clr) begin
         // prev is still captured this edge, but prev_valid=0 forces a fresh capture before comparing
         state_nxt      = SYNC;
         prev_valid_nxt = 1'b0;
         wrap_count_nxt = '0;
         err_count_nxt  = '0;
      end else begin
         case (state)
            SYNC: begin
               if (!prev_valid) begin
                  prev_valid_nxt = 1'b1;
               end else if (!is_err) begin
                  state_nxt = TRACK;
               end
            end
            TRACK: begin
               if (is_wrap) begin
                  wrap_pulse_nxt = 1'b1;
                  if (wrap_count != WRAP_MAX) begin
                     wrap_count_nxt = wrap_count + WRAP_ONE;
                  end
               end else if (is_err) begin
                  err_pulse_nxt = 1'b1;
                  err_count_nxt = err_count_inc;
                  if (err_count_inc == ERR_LIM) begin
                     state_nxt = FAULT;
                  end
               end
            end
            FAULT: begin
               state_nxt = FAULT;
            end
            default: begin
               state_nxt      = SYNC;
               prev_valid_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= SYNC;
         prev       <= '0;
         prev_valid <= 1'b0;
         wrap_count <= '0;
         err_count  <= '0;
         wrap_pulse <= 1'b0;
         err_pulse  <= 1'b0;
         locked     <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nxt;
         prev       <= count;
         prev_valid <= prev_valid_nxt;
         wrap_count <= wrap_count_nxt;
         err_count  <= err_count_nxt;
         wrap_pulse <= wrap_pulse_nxt;
         err_pulse  <= err_pulse_nxt;
         locked     <= (state_nxt == TRACK);
         fault      <= (state_nxt == FAULT);
      end
   end

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: each driven sample queues its expected outputs,
// and a monitor compares them against the DUT one cycle later.
module tb_count_seq_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic [3:0] count = 4'd0;
   logic       locked, wrap_pulse, err_pulse, fault;
   logic [1:0] wrap_count;
   logic [7:0] err_count;

   int checks   = 0;
   int failures = 0;
   int step_n   = 0;

   typedef struct packed {
      logic       locked;
      logic       wp;
      logic       ep;
      logic [1:0] wc;
      logic [7:0] ec;
      logic       fault;
   } exp_t;

   exp_t exp_q[$];
   int   id_q[$];

   count_seq_checker #(
      .CNT_WIDTH (4),
      .WRAP_WIDTH(2),
      .ERR_WIDTH (8),
      .ERR_LIMIT (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .count     (count),
      .clr       (clr),
      .locked    (locked),
      .wrap_pulse(wrap_pulse),
      .err_pulse (err_pulse),
      .wrap_count(wrap_count),
      .err_count (err_count),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int id, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s step=%0d got=%0d want=%0d", name, id, act, want);
      end
   endtask

   // Monitor: the DUT presents a registered result every cycle
   initial begin
      exp_t e;
      int   id;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            chk("locked",     id, int'(locked),     int'(e.locked));
            chk("wrap_pulse", id, int'(wrap_pulse), int'(e.wp));
            chk("err_pulse",  id, int'(err_pulse),  int'(e.ep));
            chk("wrap_count", id, int'(wrap_count), int'(e.wc));
            chk("err_count",  id, int'(err_count),  int'(e.ec));
            chk("fault",      id, int'(fault),      int'(e.fault));
         end
      end
   end

   task automatic step(input logic r, input logic c, input logic [3:0] v,
                       input logic el, input logic ewp, input logic eep,
                       input logic [1:0] ewc, input logic [7:0] eec, input logic ef);
      exp_t e;
      @(negedge clk);
      rst   = r;
      clr   = c;
      count = v;
      e = '{locked: el, wp: ewp, ep: eep, wc: ewc, ec: eec, fault: ef};
      exp_q.push_back(e);
      id_q.push_back(step_n);
      step_n++;
   endtask

   initial begin
      logic [1:0] wc;
      logic [3:0] v;

      // Reset state
      step(1, 0, 4'd0, 0, 0, 0, 2'd0, 8'd0, 0);
      step(1, 0, 4'd0, 0, 0, 0, 2'd0, 8'd0, 0);

      // Nominal counting through five rollovers: wrap_count saturates at 3
      for (int i = 0; i <= 81; i++) begin
         v  = 4'(i % 16);
         wc = (i >= 48) ? 2'd3 : 2'(i / 16);
         step(0, 0, v, (i >= 1), (i > 0 && v == 4'd0), 0, wc, 8'd0, 0);
      end

      // Skip 4 -> 6
      step(0, 0, 4'd2, 1, 0, 0, 2'd3, 8'd0, 0);
      step(0, 0, 4'd3, 1, 0, 0, 2'd3, 8'd0, 0);
      step(0, 0, 4'd4, 1, 0, 0, 2'd3, 8'd0, 0);
      step(0, 0, 4'd6, 1, 0, 1, 2'd3, 8'd1, 0);
      step(0, 0, 4'd7, 1, 0, 0, 2'd3, 8'd1, 0);
      // Hold 8, 8, 9
      step(0, 0, 4'd8, 1, 0, 0, 2'd3, 8'd1, 0);
      step(0, 0, 4'd8, 1, 0, 1, 2'd3, 8'd2, 0);
      step(0, 0, 4'd9, 1, 0, 0, 2'd3, 8'd2, 0);
      // Third error enters FAULT on the same edge
      step(0, 0, 4'd11, 0, 0, 1, 2'd3, 8'd3, 1);
      // Further errors frozen in FAULT
      step(0, 0, 4'd14, 0, 0, 0, 2'd3, 8'd3, 1);
      step(0, 0, 4'd14, 0, 0, 0, 2'd3, 8'd3, 1);
      step(0, 0, 4'd15, 0, 0, 0, 2'd3, 8'd3, 1);
      // Clear, then capture + one correct sample before locking
      step(0, 1, 4'd3, 0, 0, 0, 2'd0, 8'd0, 0);
      step(0, 0, 4'd4, 0, 0, 0, 2'd0, 8'd0, 0);
      step(0, 0, 4'd5, 1, 0, 0, 2'd0, 8'd0, 0);

      // Run to wrap_count = 2, ending on count 2
      wc = 2'd0;
      for (int k = 6; k <= 34; k++) begin
         v = 4'(k % 16);
         if (v == 4'd0) wc = wc + 2'd1;
         step(0, 0, v, 1, (v == 4'd0), 0, wc, 8'd0, 0);
      end

      // Reset with clr and a skip on the same edge
      step(1, 1, 4'd5, 0, 0, 0, 2'd0, 8'd0, 0);
      // Resync: capture 7, mismatch 9 stays in SYNC without counting, 10 locks
      step(0, 0, 4'd7, 0, 0, 0, 2'd0, 8'd0, 0);
      step(0, 0, 4'd9, 0, 0, 0, 2'd0, 8'd0, 0);
      step(0, 0, 4'd10, 1, 0, 0, 2'd0, 8'd0, 0);
      step(0, 0, 4'd11, 1, 0, 0, 2'd0, 8'd0, 0);

      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
